// File: rtl/sprite_draw_scheduler.sv
// Per-frame arbiter for the shared VGA pixel-write port: an erase pass, then a
// draw pass, over every enabled sprite requester in ascending index order.
module sprite_draw_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 4096,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_REQ-1:0]     req_en,
  output logic [NUM_REQ-1:0]     start,
  output logic                   erase,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ*9-1:0]   pix_x,
  input  logic [NUM_REQ*8-1:0]   pix_y,
  input  logic [NUM_REQ*3-1:0]   pix_colour,
  input  logic [NUM_REQ-1:0]     done,
  output logic [8:0]             x,
  output logic [7:0]             y,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [8:0]       X_LIM    = 9'(X_MAX);
  localparam logic [7:0]       Y_LIM    = 8'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEEK       = 3'd1,
    S_START      = 3'd2,
    S_WAIT       = 3'd3,
    S_ADVANCE    = 3'd4,
    S_NEXT_PHASE = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [NUM_REQ-1:0]   mask_r, mask_s;
  logic                 phase_erase_r, phase_erase_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 to_hit_s;

  logic [NUM_REQ-1:0]   start_r, start_s;
  logic                 erase_r, erase_s;
  logic                 busy_r, busy_s;
  logic                 plot_r, plot_s;
  logic [8:0]           x_r, x_s;
  logic [7:0]           y_r, y_s;
  logic [2:0]           colour_r, colour_s;
  logic                 overrun_r, overrun_s;
  logic                 timeout_err_r, timeout_err_s;

  logic [8:0]           sel_x_s;
  logic [7:0]           sel_y_s;
  logic [2:0]           sel_colour_s;
  logic                 fwd_s;

  // Next-state logic: walks the mask once per pass, erase pass first.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    mask_s        = mask_r;
    phase_erase_s = phase_erase_r;
    cnt_s         = cnt_r;
    to_hit_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (frame_tick) begin
          mask_s        = req_en;
          phase_erase_s = 1'b1;
          idx_s         = {IDX_W{1'b0}};
          state_s       = S_SEEK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SEEK: begin
        if (mask_r[idx_r]) begin
          state_s = S_START;
        end else if (idx_r == LAST_IDX) begin
          state_s = S_NEXT_PHASE;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = S_SEEK;
        end
      end
      S_START: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (done[idx_r]) begin
          state_s = S_ADVANCE;
        end else if (cnt_r == CNT_LAST) begin
          to_hit_s = 1'b1;
          state_s  = S_ADVANCE;
        end else begin
          // Saturating: the counter must never wrap back into range.
          cnt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
          state_s = S_WAIT;
        end
      end
      S_ADVANCE: begin
        if (idx_r == LAST_IDX) begin
          state_s = S_NEXT_PHASE;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = S_SEEK;
        end
      end
      S_NEXT_PHASE: begin
        if (phase_erase_r) begin
          phase_erase_s = 1'b0;
          idx_s         = {IDX_W{1'b0}};
          state_s       = S_SEEK;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output logic: controls follow the next state so the registered versions line up with it.
  always_comb begin
    start_s = {NUM_REQ{1'b0}};
    if (state_s == S_START) begin
      start_s[idx_s] = 1'b1;
    end else begin
      start_s = {NUM_REQ{1'b0}};
    end
    busy_s  = (state_s != S_IDLE);
    erase_s = phase_erase_s & busy_s;

    sel_x_s      = pix_x[int'(idx_r) * 9 +: 9];
    sel_y_s      = pix_y[int'(idx_r) * 8 +: 8];
    sel_colour_s = pix_colour[int'(idx_r) * 3 +: 3];
    fwd_s        = (state_r == S_WAIT) && pix_valid[idx_r] &&
                   (sel_x_s <= X_LIM) && (sel_y_s <= Y_LIM);

    plot_s = fwd_s;
    if (fwd_s) begin
      x_s      = sel_x_s;
      y_s      = sel_y_s;
      colour_s = sel_colour_s;
    end else begin
      x_s      = x_r;
      y_s      = y_r;
      colour_s = colour_r;
    end

    // A tick on the return-to-IDLE cycle still sees state_r busy and is dropped.
    overrun_s     = overrun_r | (frame_tick & (state_r != S_IDLE));
    timeout_err_s = timeout_err_r | to_hit_s;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      idx_r         <= {IDX_W{1'b0}};
      mask_r        <= {NUM_REQ{1'b0}};
      phase_erase_r <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      start_r       <= {NUM_REQ{1'b0}};
      erase_r       <= 1'b0;
      busy_r        <= 1'b0;
      plot_r        <= 1'b0;
      x_r           <= 9'd0;
      y_r           <= 8'd0;
      colour_r      <= 3'd0;
      overrun_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      mask_r        <= mask_s;
      phase_erase_r <= phase_erase_s;
      cnt_r         <= cnt_s;
      start_r       <= start_s;
      erase_r       <= erase_s;
      busy_r        <= busy_s;
      plot_r        <= plot_s;
      x_r           <= x_s;
      y_r           <= y_s;
      colour_r      <= colour_s;
      overrun_r     <= overrun_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign start       = start_r;
  assign erase       = erase_r;
  assign busy        = busy_r;
  assign plot        = plot_r;
  assign x           = x_r;
  assign y           = y_r;
  assign colour      = colour_r;
  assign overrun     = overrun_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: bench-side sprite engines answer start pulses
// and a frame-level model predicts grant order, plots and sticky flags.
module tb_sprite_draw_scheduler;
  localparam int N  = 3;
  localparam int TO = 16;
  localparam int XM = 319;
  localparam int YM = 239;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_tick;
  logic [N-1:0]   req_en;
  logic [N-1:0]   start;
  logic           erase;
  logic [N-1:0]   pix_valid;
  logic [N*9-1:0] pix_x;
  logic [N*8-1:0] pix_y;
  logic [N*3-1:0] pix_colour;
  logic [N-1:0]   done;
  logic [8:0]     x;
  logic [7:0]     y;
  logic [2:0]     colour;
  logic           plot, busy, overrun, timeout_err;

  always #5 clk = ~clk;

  sprite_draw_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .req_en(req_en),
    .start(start), .erase(erase), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_colour(pix_colour), .done(done), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [2:0] en;
    logic [2:0] nodone;
    int         npix;
    int         sim;        // 0 done after last pixel, 1 with it, 2 random
    bit         rnd;        // include out-of-range and corner coordinates
    bit         tick_mid;   // extra frame_tick while a requester is granted
    int         exp_plots;  // -1: not checked
    int         exp_ovr;
    int         exp_to;
  } vec_t;

  vec_t tbl[5];
  int   bx[4] = '{320, 319, 319, 0};
  int   by[4] = '{10, 239, 240, 0};

  int n_cmp = 0, n_bad = 0;

  // Model state
  int         exp_starts[$];
  int         gnt = -1, pend = -1, wcnt = 0, left = 0, bcnt = 0, plot_cnt = 0;
  bit         cur_erase = 1'b0, cur_sim = 1'b0, cur_rnd = 1'b0;
  logic [2:0] cur_nodone = 3'b000;
  int         cur_npix = 1;
  bit         nexp_plot = 1'b0;
  logic [8:0] nexp_x = 9'd0, exp_x = 9'd0;
  logic [7:0] nexp_y = 8'd0, exp_y = 8'd0;
  logic [2:0] nexp_c = 3'd0, exp_c = 3'd0;
  bit         exp_ovr = 1'b0, exp_to = 1'b0, ovr_pend = 1'b0, to_pend = 1'b0;
  bit         tick_req = 1'b0, tick_busy = 1'b0, quiet = 1'b1;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  // One clock: check what the last edge produced, then drive the next inputs.
  task automatic step();
    int e;
    logic [8:0] px;
    logic [7:0] py;
    logic [2:0] pc;
    bit emit, fin;
    @(posedge clk);
    #1;
    if (nexp_plot) begin
      exp_x = nexp_x; exp_y = nexp_y; exp_c = nexp_c;
    end
    exp_ovr = exp_ovr | ovr_pend;
    exp_to  = exp_to | to_pend;
    ovr_pend = 1'b0;
    to_pend  = 1'b0;
    chk("plot", plot, nexp_plot);
    chk("x", x, exp_x);
    chk("y", y, exp_y);
    chk("colour", colour, exp_c);
    chk("overrun", overrun, exp_ovr);
    chk("timeout_err", timeout_err, exp_to);
    if (plot === 1'b1) plot_cnt++;
    if (pend >= 0) begin
      gnt = pend; pend = -1; wcnt = 0; left = cur_npix;
    end
    if (gnt >= 0) begin
      chk("busy_in_wait", busy, 1);
      chk("erase_hold", erase, cur_erase);
    end
    if (start !== 3'b000) begin
      if (exp_starts.size() == 0) begin
        chk("start_unexpected", start, 0);
      end else begin
        e = exp_starts.pop_front();
        chk("start_order", start, 1 << (e % 4));
        chk("start_erase", erase, e / 4);
        pend = e % 4;
        cur_erase = (e / 4) != 0;
      end
    end

    nexp_plot  = 1'b0;
    frame_tick = tick_req;
    if (tick_req && (tick_busy || gnt >= 0)) ovr_pend = 1'b1;
    tick_req  = 1'b0;
    tick_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      pix_valid[i]       = quiet ? 1'b0 : 1'($urandom % 2);
      pix_x[i*9 +: 9]    = 9'($urandom);
      pix_y[i*8 +: 8]    = 8'($urandom);
      pix_colour[i*3 +: 3] = 3'($urandom);
      done[i]            = quiet ? 1'b0 : ($urandom % 8 == 0);
    end
    if (gnt >= 0) begin
      pix_valid[gnt] = 1'b0;
      done[gnt]      = 1'b0;
      wcnt++;
      fin  = 1'b0;
      emit = (left > 0) && !(wcnt < 8 && $urandom % 4 == 0);
      if (emit) begin
        if (cur_rnd && $urandom % 2 == 0) begin
          px = 9'(bx[bcnt % 4]); py = 8'(by[bcnt % 4]); bcnt++;
        end else if (cur_rnd) begin
          px = 9'($urandom_range(0, 340)); py = 8'($urandom_range(0, 250));
        end else begin
          px = 9'($urandom_range(0, XM)); py = 8'($urandom_range(0, YM));
        end
        pc = 3'($urandom);
        pix_x[gnt*9 +: 9] = px;
        pix_y[gnt*8 +: 8] = py;
        pix_colour[gnt*3 +: 3] = pc;
        pix_valid[gnt] = 1'b1;
        left--;
        if (int'(px) <= XM && int'(py) <= YM) begin
          nexp_plot = 1'b1; nexp_x = px; nexp_y = py; nexp_c = pc;
        end
        if (left == 0 && !cur_nodone[gnt] && cur_sim) begin
          done[gnt] = 1'b1; fin = 1'b1;
        end
      end else if (left == 0 && !cur_nodone[gnt]) begin
        done[gnt] = 1'b1; fin = 1'b1;
      end
      if (!fin && cur_nodone[gnt] && wcnt == TO) begin
        fin = 1'b1; to_pend = 1'b1;
      end
      if (fin) gnt = -1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; quiet = 1'b1;
    frame_tick = 1'b0; pix_valid = '0; done = '0;
    nexp_plot = 1'b0; exp_x = 9'd0; exp_y = 8'd0; exp_c = 3'd0;
    exp_ovr = 1'b0; exp_to = 1'b0; ovr_pend = 1'b0; to_pend = 1'b0;
    tick_req = 1'b0; tick_busy = 1'b0;
    gnt = -1; pend = -1;
    exp_starts.delete();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_erase", erase, 0);
    reset = 1'b1; quiet = 1'b0;
  endtask

  task automatic arm_frame(input vec_t v);
    req_en = v.en; cur_nodone = v.nodone; cur_npix = v.npix; cur_rnd = v.rnd;
    cur_sim = (v.sim == 2) ? 1'($urandom % 2) : (v.sim == 1);
    for (int ph = 1; ph >= 0; ph--)
      for (int i = 0; i < N; i++)
        if (v.en[i]) exp_starts.push_back(i + 4 * ph);
    plot_cnt = 0;
    tick_req = 1'b1;
    step();
    step();
    req_en = 3'($urandom);  // mask is latched at the accepted tick
  endtask

  task automatic run_frame(input vec_t v);
    int guard;
    bit mid;
    arm_frame(v);
    mid = v.tick_mid;
    guard = 0;
    while ((exp_starts.size() > 0 || gnt >= 0 || pend >= 0) && guard < 600) begin
      if (mid && gnt >= 0) begin tick_req = 1'b1; mid = 1'b0; end
      step();
      guard++;
    end
    chk("frame_walk", exp_starts.size() + int'(gnt >= 0) + int'(pend >= 0), 0);
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin step(); guard++; end
    chk("busy_fall", busy, 0);
    if (v.exp_plots >= 0) chk("plot_count", plot_cnt, v.exp_plots);
    if (v.exp_ovr >= 0)   chk("overrun_frame", overrun, v.exp_ovr);
    if (v.exp_to >= 0)    chk("timeout_frame", timeout_err, v.exp_to);
  endtask

  initial begin
    vec_t rv;
    int guard;
    tbl[0] = '{3'b111, 3'b000, 2, 0, 1'b0, 1'b0, 12, 0, 0};
    tbl[1] = '{3'b101, 3'b000, 2, 1, 1'b0, 1'b0,  8, 0, 0};
    tbl[2] = '{3'b111, 3'b010, 2, 2, 1'b0, 1'b0, 12, 0, 1};
    tbl[3] = '{3'b111, 3'b000, 2, 2, 1'b0, 1'b1, 12, 1, 1};
    tbl[4] = '{3'b110, 3'b000, 3, 2, 1'b1, 1'b0, -1, 1, 1};
    req_en = '0; frame_tick = 1'b0; pix_valid = '0; done = '0;
    pix_x = '0; pix_y = '0; pix_colour = '0;

    do_reset();
    repeat (3) step();

    for (int k = 0; k < 5; k++) run_frame(tbl[k]);

    // Reset while a requester is being served
    rv = '{3'b111, 3'b000, 4, 0, 1'b0, 1'b0, -1, -1, -1};
    arm_frame(rv);
    guard = 0;
    while (gnt < 0 && guard < 40) begin step(); guard++; end
    chk("wait_reached", int'(gnt >= 0), 1);
    step();
    do_reset();
    chk("rst_mid_overrun", overrun, 0);
    chk("rst_mid_timeout", timeout_err, 0);
    step();
    chk("rst_mid_idle", busy, 0);

    // Empty mask: eight walk cycles, and a tick on the return-to-IDLE cycle is dropped
    rv = '{3'b000, 3'b000, 1, 0, 1'b0, 1'b0, 0, 0, 0};
    req_en = 3'b000;
    tick_req = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin tick_req = 1'b1; tick_busy = 1'b1; end
      step();
      chk("empty_busy", busy, 1);
    end
    step();
    chk("empty_idle", busy, 0);
    chk("return_tick_overrun", overrun, 1);
    step();
    chk("return_tick_dropped", busy, 0);

    rv = '{3'b111, 3'b000, 2, 1, 1'b0, 1'b0, 12, 1, 0};
    run_frame(rv);

    for (int k = 0; k < 8; k++) begin
      rv.en       = 3'($urandom);
      rv.nodone   = ($urandom % 4 == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      rv.npix     = $urandom_range(1, 4);
      rv.sim      = 2;
      rv.rnd      = 1'b1;
      rv.tick_mid = 1'($urandom % 2);
      rv.exp_plots = -1; rv.exp_ovr = -1; rv.exp_to = -1;
      run_frame(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Per-frame scheduler that shares the single VGA pixel-write port between the sprite engines (player, alien block, bullet).
- On each frame tick it runs an erase pass, then a draw pass, over every enabled requester in fixed index order.
- For each requester it pulses a start strobe, forwards only that requester's pixel stream to the VGA port, and waits for its done.
- It replaces the ad-hoc ldp/lda/ldb sequencing feeding the pixel mux.

Parameters:
- NUM_REQ, 3, number of sprite requesters; index 0 = player, 1 = aliens, 2 = bullet; lower index is served first.
- TIMEOUT, 4096, maximum cycles allowed between a start pulse and done before the scheduler forces an advance.
- X_MAX, 319, largest legal x coordinate.
- Y_MAX, 239, largest legal y coordinate.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at the frame rate (1/60 s); starts a frame.
- req_en  in  NUM_REQ  per-requester participation; sampled on an accepted frame_tick.
- start  out  NUM_REQ  one-hot, one-cycle grant-start pulse.
- erase  out  1  1 during the erase pass, 0 during the draw pass; valid alongside start and the grant.
- pix_valid  in  NUM_REQ  per-requester pixel strobe.
- pix_x  in  NUM_REQ*9  packed x coordinates; requester i uses bits [9i+8:9i].
- pix_y  in  NUM_REQ*8  packed y coordinates.
- pix_colour  in  NUM_REQ*3  packed colours.
- done  in  NUM_REQ  requester i has finished its current pass.
- x  out  9  registered VGA x.
- y  out  8  registered VGA y.
- colour  out  3  registered VGA colour.
- plot  out  1  registered VGA write enable.
- busy  out  1  high from an accepted frame_tick until return to IDLE.
- overrun  out  1  sticky; set when a frame_tick arrives while busy.
- timeout_err  out  1  sticky; set when a requester exceeds TIMEOUT.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; start, erase, plot, busy, overrun, timeout_err = 0; x, y, colour = 0; mask and counters cleared.
- Reset asserted mid-frame aborts immediately. No further start pulses are issued. plot is 0 from the next edge on.
- States:
  - IDLE: on frame_tick, mask <= req_en, phase <= ERASE, idx <= 0, go to SEEK.
  - SEEK: if mask[idx]==1, go to START. Else if idx == NUM_REQ-1, go to NEXT_PHASE. Else idx++ and stay in SEEK.
  - START: start[idx]=1 for exactly this cycle; timeout counter <= 0; go to WAIT.
  - WAIT: grant = idx. On done[idx], or counter == TIMEOUT-1, go to ADVANCE. A timeout sets timeout_err.
  - ADVANCE: if idx == NUM_REQ-1, go to NEXT_PHASE. Else idx++ and go to SEEK.
  - NEXT_PHASE: if phase==ERASE, phase <= DRAW, idx <= 0, go to SEEK. Else go to IDLE.
- erase = (phase==ERASE), held constant through SEEK, START, WAIT and ADVANCE of that pass.
- busy = (state != IDLE).
- Pixel forwarding happens only in WAIT and only for the granted index. x, y and colour register that requester's fields one cycle after pix_valid, and plot=1 on that same cycle.
- Pixels from non-granted requesters, or outside WAIT, are dropped (plot=0).
- A pixel with x > X_MAX or y > Y_MAX is dropped (plot=0). x, y and colour hold their previous values.
- If pix_valid and done rise in the same cycle, that pixel is forwarded and the scheduler advances.
- plot is 0 in every cycle that has no forwarded pixel. x, y and colour hold otherwise.
- An empty mask still walks SEEK→NEXT_PHASE for both phases, issues no start pulse, and returns to IDLE.
- frame_tick while busy: the tick is dropped, overrun <= 1, and the current frame is unaffected.
- frame_tick in the same cycle as the return to IDLE counts as busy and is dropped.
- A done received while the requester is not granted is ignored.
- Sticky flags clear only on reset.
- The timeout counter is wide enough for TIMEOUT and saturates; it never wraps.

Test Plan:
- Nominal frame: req_en=3'b111, frame_tick; each requester sends 2 pixels then done.
  - Required start pulse order: 0,1,2 with erase=1, then 0,1,2 with erase=0.
  - 12 plot pulses, each one cycle after its pix_valid with the matching x/y/colour.
  - busy then falls.
- Masked requester: req_en=3'b101 → no start[1] pulse in either pass. Pixels driven on requester 1 throughout produce no plot.
- Timeout: requester 1 never asserts done (TIMEOUT=16) → advance after 16 WAIT cycles, timeout_err=1, start[2] follows, frame completes.
- Overrun and bounds:
  - frame_tick during WAIT → overrun=1, frame order unchanged.
  - A pixel at x=320,y=10 → plot=0.
  - A pixel at x=319,y=239 → plot=1.
- Simultaneous and reset:
  - pix_valid and done in the same cycle → pixel plotted and next start issued.
  - reset low mid-WAIT → next cycle busy=0, plot=0, all flags 0, state IDLE; a later frame_tick runs normally.
